// File: rtl/grid_scan_driver.sv
// Row-multiplexed 8x8 LED driver for the Game of Life grid. Generations are
// double-buffered and only swapped into the display on entry to row 0.
module grid_scan_driver #(
  parameter int ROW_DWELL    = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] grid_in,
  input  logic        grid_valid,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_start
);

  localparam int CNT_MAX = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(ROW_DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_idx_q, row_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0][7:0] disp_buf_q, disp_buf_d;
  logic [63:0]     pend_buf_q, pend_buf_d;
  logic            pend_flag_q, pend_flag_d;
  logic [7:0]      row_sel_q, row_sel_d;
  logic [7:0]      col_data_q, col_data_d;
  logic            frame_start_q;
  logic            swap;

  // Next state; swap marks every entry into row 0 ACTIVE.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    swap      = 1'b0;
    case (state_q)
      IDLE: begin
        row_idx_d = 3'd0;
        cnt_d     = '0;
        if (enable) begin
          state_d = ACTIVE;
          swap    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) begin
            row_idx_d = row_idx_q + 3'd1;
            swap      = (row_idx_q == 3'd7);
          end else begin
            state_d = BLANK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d     = '0;
          state_d   = ACTIVE;
          row_idx_d = row_idx_q + 3'd1;
          swap      = (row_idx_q == 3'd7);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable aborts immediately, even mid-row.
    if (!enable) begin
      state_d   = IDLE;
      row_idx_d = 3'd0;
      cnt_d     = '0;
      swap      = 1'b0;
    end
  end

  // Buffering and registered output values derived from the next state.
  always_comb begin
    disp_buf_d  = disp_buf_q;
    pend_buf_d  = pend_buf_q;
    pend_flag_d = pend_flag_q;
    if (grid_valid) begin
      pend_buf_d  = grid_in;
      pend_flag_d = 1'b1;
    end
    if (swap) begin
      // A strobe on the swap edge is newer than anything pending.
      if (grid_valid)       disp_buf_d = grid_in;
      else if (pend_flag_q) disp_buf_d = pend_buf_q;
      pend_flag_d = 1'b0;
    end
    row_sel_d  = 8'h00;
    col_data_d = 8'h00;
    if (state_d == ACTIVE) begin
      row_sel_d  = 8'b1 << row_idx_d;
      col_data_d = disp_buf_d[row_idx_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      row_idx_q     <= 3'd0;
      cnt_q         <= '0;
      disp_buf_q    <= '0;
      pend_buf_q    <= '0;
      pend_flag_q   <= 1'b0;
      row_sel_q     <= 8'h00;
      col_data_q    <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_idx_q     <= row_idx_d;
      cnt_q         <= cnt_d;
      disp_buf_q    <= disp_buf_d;
      pend_buf_q    <= pend_buf_d;
      pend_flag_q   <= pend_flag_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      frame_start_q <= swap;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_grid_scan_driver.sv
// Directed bench for grid_scan_driver with ROW_DWELL=4, BLANK_CYCLES=2.
module tb_grid_scan_driver;
  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int ROWP  = RD + BC;
  localparam int FRAME = 8 * ROWP;

  localparam logic [63:0] DIAG = 64'h8040201008040201;
  localparam logic [63:0] G_FF = 64'h00000000000000FF;
  localparam logic [63:0] G_R1 = 64'h000000000000FF00;
  localparam logic [63:0] G_AA = 64'h00000000000000AA;
  localparam logic [63:0] G_I  = 64'h5500000000003300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] grid_in = '0;
  logic        grid_valid = 1'b0;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_start;

  int n_chk = 0;
  int n_err = 0;

  grid_scan_driver #(.ROW_DWELL(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .grid_in(grid_in),
    .grid_valid(grid_valid), .row_sel(row_sel), .col_data(col_data),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " row_sel"}, 64'(row_sel), 64'h0);
    chk({tag, " col_data"}, 64'(col_data), 64'h0);
    chk({tag, " frame_start"}, 64'(frame_start), 64'h0);
  endtask

  // Called at the falling edge of frame cycle 0; checks ncyc cycles of a frame
  // showing g, optionally strobing v1/v2 after checking cycles s1/s2.
  task automatic run_frame(input string tag, input logic [63:0] g, input int ncyc,
                           input int s1, input logic [63:0] v1,
                           input int s2, input logic [63:0] v2);
    int r, ph;
    logic [7:0] rs, cd;
    logic [63:0] gl;
    gl = g;
    for (int i = 0; i < ncyc; i++) begin
      r  = i / ROWP;
      ph = i % ROWP;
      rs = (ph < RD) ? 8'(1 << r) : 8'h00;
      cd = (ph < RD) ? gl[r*8 +: 8] : 8'h00;
      chk($sformatf("%s c%0d row_sel", tag, i), 64'(row_sel), 64'(rs));
      chk($sformatf("%s c%0d col_data", tag, i), 64'(col_data), 64'(cd));
      chk($sformatf("%s c%0d frame_start", tag, i), 64'(frame_start), 64'(i == 0));
      grid_valid = 1'b0;
      if (i == s1) begin grid_valid = 1'b1; grid_in = v1; end
      if (i == s2) begin grid_valid = 1'b1; grid_in = v2; end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_dark("reset");
    chk("reset pend_flag", 64'(dut.pend_flag_q), 64'h0);
    reset = 1'b1;
    @(negedge clk);
    chk_dark("idle");
    enable = 1'b1;
    @(negedge clk);

    // Empty grid scanning and wrap.
    run_frame("t1a", '0, FRAME, -1, '0, -1, '0);
    run_frame("t1b", '0, FRAME, 10, DIAG, -1, '0);
    run_frame("t2", DIAG, FRAME, 5, G_FF, 20, G_R1);
    // Strobe on the wrap edge lands in the frame that edge starts.
    run_frame("t3", G_R1, FRAME, FRAME - 1, G_AA, -1, '0);
    chk("t4 pend_flag", 64'(dut.pend_flag_q), 64'h0);
    run_frame("t4a", G_AA, FRAME, -1, '0, -1, '0);
    run_frame("t4b", G_AA, 20, -1, '0, -1, '0);

    // Abort mid row 3, capture while idle, restart at row 0.
    enable = 1'b0;
    @(negedge clk);
    chk_dark("t5 abort");
    grid_valid = 1'b1;
    grid_in    = G_I;
    @(negedge clk);
    grid_valid = 1'b0;
    @(negedge clk);
    chk_dark("t5 idle");
    enable = 1'b1;
    @(negedge clk);
    run_frame("t5", G_I, 8, -1, '0, -1, '0);

    // Asynchronous reset in the middle of row 1.
    chk("t6 pre row_sel", 64'(row_sel), 64'h02);
    chk("t6 pre col_data", 64'(col_data), 64'h33);
    reset = 1'b0;
    #1;
    chk_dark("t6 async");
    @(negedge clk);
    chk_dark("t6 held");
    reset = 1'b1;
    @(negedge clk);
    run_frame("t6", '0, FRAME, -1, '0, -1, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/grid_scan_driver.md
# grid_scan_driver

Display back-end for the 64-bit Game of Life grid: consumes each generation the `Game` core publishes on its 64-bit grid output. Drives an 8x8 LED matrix by row multiplexing, one row lit at a time, with blanking between rows. New generations are double-buffered and swapped only at frame boundaries, so no frame ever shows a mix of two generations.

## Interface

Parameters:
- `ROW_DWELL`, default 1000: cycles each row is lit; legal range ≥ 1.
- `BLANK_CYCLES`, default 16: all-dark cycles after each row; 0 means no blanking.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 resets the block.
- `enable`  input  1  scanning runs while 1.
- `grid_in`  input  64  generation from the Game core; bit `r*8+c` is row r, column c.
- `grid_valid`  input  1  one-cycle strobe; `grid_in` is valid this cycle.
- `row_sel`  output  8  one-hot row drive, active high; bit r drives row r.
- `col_data`  output  8  column drive for the lit row; bit c = `grid[r*8+c]`.
- `frame_start`  output  1  one-cycle pulse on the first lit cycle of row 0.

## Operation

- Storage:
  - `pend_buf[63:0]` and `pend_flag`: newest unconsumed generation.
  - `disp_buf[63:0]`: generation currently shown.
  - `row_idx[2:0]`, dwell/blank counter of width `$clog2(max(ROW_DWELL,BLANK_CYCLES)+1)`.
- Capture:
  - `grid_valid`=1 → `pend_buf <= grid_in`, `pend_flag <= 1`.
  - A later strobe before the swap overwrites the earlier one; only the newest generation is kept.
- FSM states: IDLE, ACTIVE, BLANK.
  - IDLE: `row_sel`=0, `col_data`=0, `row_idx`=0. Goes to ACTIVE (row 0) when `enable`=1.
  - ACTIVE: `row_sel = 1<<row_idx`, `col_data = disp_buf[row_idx*8 +: 8]`. Lasts exactly `ROW_DWELL` cycles. Then goes to BLANK, or, if `BLANK_CYCLES`=0, straight to the next row's ACTIVE.
  - BLANK: `row_sel`=0, `col_data`=0 for `BLANK_CYCLES` cycles. Then `row_idx <= row_idx+1` (wraps 7→0) and goes to ACTIVE.
- Frame swap, performed on every entry into row 0 ACTIVE (from IDLE or from wrap):
  - If `pend_flag`: `disp_buf <= pend_buf`, `pend_flag <= 0`.
  - If `grid_valid` is asserted in the same cycle as the swap: `grid_in` loads `disp_buf` directly and `pend_flag` stays 0. The newest value always wins.
- `frame_start` is 1 for exactly the first ACTIVE cycle of row 0, and 0 at all other times.
- `enable`=0 in any state → IDLE on the next edge and outputs go dark. This aborts mid-row with no completion of the row. Capture continues while idle.
- Reset (async, `reset`=0):
  - State = IDLE; `row_sel`, `col_data`, `frame_start`, `row_idx`, counter, `disp_buf`, `pend_buf`, `pend_flag` all = 0.
  - Takes effect immediately, mid-row included.
  - Deassertion is synchronous to the first following edge; a `grid_valid` coincident with that edge is captured.

## Timing

- All outputs are registered; no combinational path from input to output.
- Startup latency: `enable` sampled 1 at edge k → row 0 lit and `frame_start`=1 in the cycle after edge k.
- Frame period: `8*(ROW_DWELL+BLANK_CYCLES)` cycles; rows 0..7 in order.
- A generation strobed during frame F is displayed starting at frame F+1. A strobe coincident with the swap edge is displayed in the frame that edge starts.
- `row_sel` never has more than one bit set. `row_sel` and `col_data` change on the same edge.

## Test plan

Bench runs with `ROW_DWELL`=4, `BLANK_CYCLES`=2, so a frame is 48 cycles.

1. Reset, then `enable`=1:
   - `frame_start` pulses every 48 cycles.
   - `row_sel` sequence per row: 01,01,01,01,00,00, then 02 ×4, …, 80 ×4, then wraps to 01.
   - `col_data`=00 throughout (disp_buf is 0).
2. Strobe `grid_in`=64'h8040201008040201 mid-frame:
   - Current frame still shows 00.
   - From the next `frame_start`, `col_data` for row r = `1<<r`.
3. Strobe 64'hFF, then 64'hFF00 in the same frame:
   - Next frame row 0 = 00, row 1 = FF.
   - 64'hFF is never displayed.
4. Strobe `grid_in`=64'h00000000000000AA on exactly the wrap edge:
   - Row 0 = AA in the frame that edge starts.
   - `pend_flag` is 0 afterwards.
5. Drop `enable` during row 3 ACTIVE:
   - Next cycle `row_sel`=0 and `col_data`=0.
   - Re-enable → restarts at row 0 with `frame_start`=1 one cycle later.
6. Assert `reset`=0 mid-row with a nonzero `disp_buf`:
   - Outputs go 0 immediately, without waiting for a clock edge.
   - After release with `enable`=1, all rows show 00 until a new strobe is captured.
